// File: rtl/ppu_palette_ram.sv
// rtl/ppu_palette_ram.sv - 32-entry NES palette RAM with backdrop mirroring, 6-bit storage and clear sequence
// Optional feature macro: PPU_PALETTE_GREYSCALE_EN (adds greyscale input that keeps only the luma bits on reads)
module ppu_palette_ram #(
  parameter logic [7:0] INIT_VALUE = 8'h0F,
  parameter logic [7:0] DATA_MASK  = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] vram_addr,
  output logic [7:0]  vram_data_out,
  output logic        vram_hit,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        clear_start,
`ifdef PPU_PALETTE_GREYSCALE_EN
  input  logic        greyscale,
`endif
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;

  localparam logic [7:0] INIT_MASKED = INIT_VALUE & DATA_MASK;

  logic [7:0] r_mem [32];
  logic [1:0] r_state;
  logic [4:0] r_cnt;
  logic       r_busy;
  logic [7:0] r_rd_data;
  logic       r_rd_hit;
  logic       r_wr_ack;

  logic       w_rd_pal;
  logic [4:0] w_rd_idx;
  logic       w_wr_ok;
  logic [4:0] w_wr_idx;
  logic [7:0] w_wr_val;
  logic [7:0] w_rd_raw;
  logic [7:0] w_rd_val;
  logic       w_unused;

  // Backdrop entries 10/14/18/1C share storage with 00/04/08/0C.
  function automatic logic [4:0] mirror_idx(input logic [4:0] idx);
    if (idx[4] && (idx[1:0] == 2'b00)) begin
      return {1'b0, idx[3:0]};
    end
    return idx;
  endfunction

  assign w_rd_pal = (vram_addr[15:8] == 8'h3F);
  assign w_rd_idx = mirror_idx(vram_addr[4:0]);
  assign w_wr_ok  = wr_en && (wr_addr[15:8] == 8'h3F) && (r_state == S_IDLE);
  assign w_wr_idx = mirror_idx(wr_addr[4:0]);
  assign w_wr_val = wr_data & DATA_MASK;

  // A write landing on the entry being read this edge is forwarded so the reader never sees stale data.
  assign w_rd_raw = (w_wr_ok && (w_wr_idx == w_rd_idx)) ? w_wr_val : (r_mem[w_rd_idx] & DATA_MASK);

`ifdef PPU_PALETTE_GREYSCALE_EN
  assign w_rd_val = greyscale ? (w_rd_raw & 8'h30) : w_rd_raw;
`else
  assign w_rd_val = w_rd_raw;
`endif

  assign w_unused = ^{vram_addr[7:5], wr_addr[7:5]};

  // Clear sequencer: one entry per cycle, exactly 32 cycles, never re-armed mid-sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            r_state <= S_CLEAR;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == 5'd31) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 5'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: clear sequence owns the array while running, CPU writes otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= INIT_MASKED;
      end
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= INIT_MASKED;
    end else if (w_wr_ok) begin
      r_mem[w_wr_idx] <= w_wr_val;
    end
  end

  // Registered read response and write acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 8'h00;
      r_rd_hit  <= 1'b0;
      r_wr_ack  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_pal ? w_rd_val : 8'h00;
      r_rd_hit  <= w_rd_pal;
      r_wr_ack  <= w_wr_ok;
    end
  end

  assign vram_data_out = r_rd_data;
  assign vram_hit      = r_rd_hit;
  assign wr_ack        = r_wr_ack;
  assign busy          = r_busy;

endmodule

// File: tb/tb_ppu_palette_ram.sv
// tb/tb_ppu_palette_ram.sv - directed self-checking bench for ppu_palette_ram
module tb_ppu_palette_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data_out;
  logic        vram_hit;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        clear_start;
  logic        busy;
`ifdef PPU_PALETTE_GREYSCALE_EN
  logic        greyscale = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  ppu_palette_ram dut (
    .clk           (clk),
    .rst           (rst),
    .vram_addr     (vram_addr),
    .vram_data_out (vram_data_out),
    .vram_hit      (vram_hit),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .clear_start   (clear_start),
`ifdef PPU_PALETTE_GREYSCALE_EN
    .greyscale     (greyscale),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input logic [15:0] addr, input logic [7:0] exp_d, input logic exp_h, input string name);
    vram_addr = addr;
    step();
    checks++;
    if (vram_data_out !== exp_d || vram_hit !== exp_h) begin
      failures++;
      $display("FAIL %s addr=%h data=%h hit=%b expected data=%h hit=%b", name, addr, vram_data_out, vram_hit, exp_d, exp_h);
    end
  endtask

  task automatic write_check(input logic [15:0] addr, input logic [7:0] data, input logic exp_ack, input string name);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    step();
    wr_en = 1'b0;
    checks++;
    if (wr_ack !== exp_ack) begin
      failures++;
      $display("FAIL %s wr_ack=%b expected %b", name, wr_ack, exp_ack);
    end
  endtask

  task automatic test_reset();
    vram_addr = 16'h3F00; wr_en = 1'b0; wr_addr = 16'h0; wr_data = 8'h0; clear_start = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (vram_data_out !== 8'h00 || vram_hit !== 1'b0 || wr_ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs data=%h hit=%b ack=%b busy=%b expected 00 0 0 0", vram_data_out, vram_hit, wr_ack, busy);
    end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_read_all(input string name);
    for (int i = 0; i < 32; i++) begin
      read_check(16'h3F00 + 16'(i), 8'h0F, 1'b1, name);
    end
    read_check(16'h2000, 8'h00, 1'b0, {name, "_nonpal"});
  endtask

  task automatic test_write_mirror();
    write_check(16'h3F10, 8'hFF, 1'b1, "wr_ack_3f10");
    step();
    checks++;
    if (wr_ack !== 1'b0) begin
      failures++;
      $display("FAIL wr_ack_single_pulse wr_ack=%b expected 0", wr_ack);
    end
    read_check(16'h3F00, 8'h3F, 1'b1, "mirror_3f00");
    read_check(16'h3F10, 8'h3F, 1'b1, "mirror_3f10");
    write_check(16'h3F11, 8'h21, 1'b1, "wr_ack_3f11");
    read_check(16'h3F01, 8'h0F, 1'b1, "nomirror_3f01");
    read_check(16'h3F11, 8'h21, 1'b1, "nomirror_3f11");
    write_check(16'h2005, 8'h12, 1'b0, "wr_nonpal_ack");
    read_check(16'h3F05, 8'h0F, 1'b1, "wr_nonpal_ignored");
  endtask

  task automatic test_write_through();
    wr_en = 1'b1; wr_addr = 16'h3F05; wr_data = 8'h2A; vram_addr = 16'h3F05;
    step();
    wr_en = 1'b0;
    checks++;
    if (vram_data_out !== 8'h2A) begin
      failures++;
      $display("FAIL write_through_3f05 data=%h expected 2a", vram_data_out);
    end
    wr_en = 1'b1; wr_addr = 16'h3F1C; wr_data = 8'hD1; vram_addr = 16'h3F0C;
    step();
    wr_en = 1'b0;
    checks++;
    if (vram_data_out !== 8'h11) begin
      failures++;
      $display("FAIL write_through_mirror data=%h expected 11", vram_data_out);
    end
  endtask

  task automatic test_fill_and_load();
    logic [255:0] img;
    logic [255:0] exp_img;
    for (int i = 0; i < 32; i++) begin
      write_check(16'h3F00 + 16'(i), 8'(i), 1'b1, "fill_ack");
    end
    img = '0;
    exp_img = '0;
    for (int i = 0; i < 32; i++) begin
      exp_img[i*8 +: 8] = (i[1:0] == 2'b00) ? 8'(i | 16) : 8'(i);
    end
    vram_addr = 16'h3F00;
    step();
    for (int i = 1; i <= 32; i++) begin
      img[(i-1)*8 +: 8] = vram_data_out;
      vram_addr = 16'h3F00 + 16'(i % 32);
      step();
    end
    checks++;
    if (img !== exp_img) begin
      failures++;
      $display("FAIL loader_image got=%h expected=%h", img, exp_img);
    end
  endtask

  task automatic test_clear();
    int cnt;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      wr_en = (cnt == 10); wr_addr = 16'h3F02; wr_data = 8'h33;
      clear_start = (cnt == 12);
      step();
      wr_en = 1'b0; clear_start = 1'b0;
      if (cnt == 10) begin
        checks++;
        if (wr_ack !== 1'b0) begin
          failures++;
          $display("FAIL wr_during_clear_ack wr_ack=%b expected 0", wr_ack);
        end
      end
    end
    checks++;
    if (cnt != 32) begin
      failures++;
      $display("FAIL clear_busy_cycles busy_cycles=%0d expected 32", cnt);
    end
    test_read_all("after_clear");
  endtask

  task automatic test_reset_mid_clear();
    write_check(16'h3F1F, 8'h15, 1'b1, "pre_clear_wr");
    write_check(16'h3F03, 8'h07, 1'b1, "pre_clear_wr");
    clear_start = 1'b1;
    vram_addr = 16'h3F03;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (busy !== 1'b1 || vram_hit !== 1'b1) begin
      failures++;
      $display("FAIL mid_clear_state busy=%b hit=%b expected 1 1", busy, vram_hit);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || vram_data_out !== 8'h00 || vram_hit !== 1'b0 || wr_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear busy=%b data=%h hit=%b ack=%b expected 0 00 0 0", busy, vram_data_out, vram_hit, wr_ack);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear_no_resume busy=%b expected 0", busy);
    end
    test_read_all("after_reset_mid_clear");
  endtask

  initial begin
    test_reset();
    test_read_all("reset_read");
    test_write_mirror();
    test_write_through();
    test_fill_and_load();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
